sprite_rle_loader: RTL
======================

# sprite_rle_loader

Run-length decoder and writer for the sprite image memory. It accepts an RLE-compressed byte stream of 8-bit palette indices, for example from the UART or host loader. It expands each run into sequential raster-order writes on the image BRAM write port. The sprite renderer reads back the same `WIDTH*HEIGHT` array of palette indices.

## Interface
Parameters:
- `WIDTH`, 256: sprite width in pixels.
- `HEIGHT`, 256: sprite height in pixels.
- `AW`, `$clog2(WIDTH*HEIGHT)`: derived write-address width.

Ports (one clock; reset is synchronous and active-high):
- `pixel_clk_in`  input  1: the only clock.
- `rst_in`  input  1: synchronous, active-high reset.
- `start_in`  input  1: arms a new frame load; honoured only in IDLE.
- `byte_in`  input  8: stream data.
- `byte_valid_in`  input  1: `byte_in` is valid.
- `byte_ready_out`  output  1: loader can accept a byte this cycle.
- `wr_addr_out`  output  AW: BRAM write address.
- `wr_data_out`  output  8: palette index to write.
- `wr_en_out`  output  1: write strobe (BRAM `wea`).
- `busy_out`  output  1: frame load in progress.
- `done_out`  output  1: one-cycle pulse when the frame is complete.
- `error_out`  output  1: sticky; a run overran the frame.

## Operation
Stream format:
- The stream is a sequence of pairs: count byte C, then index byte I.
- The run length is C+1, range 1..256.
- A frame is exactly `WIDTH*HEIGHT` pixels, written to addresses 0 .. `WIDTH*HEIGHT`-1 in order (address = y*`WIDTH`+x).

Handshake:
- A byte transfers on any rising edge where `byte_valid_in && byte_ready_out`.
- `byte_ready_out` is combinational from state only: high in GET_COUNT and GET_INDEX, low otherwise.
- Source must hold `byte_in` stable while valid and not accepted.

FSM:
- IDLE: `busy_out`=0. `start_in`=1 → GET_COUNT; clear the pixel counter, address and `error_out`.
- GET_COUNT: on transfer, latch `run_len` = C+1 → GET_INDEX.
- GET_INDEX: on transfer, latch I into `wr_data_out` → WRITE.
- WRITE: one write per cycle.
  - Each cycle: `wr_en_out`=1 at the current address; increment the address; decrement both `run_len` and `pixels_left`.
  - Last pixel of the frame written → DONE. This takes priority over the run ending.
  - Otherwise, run ends → GET_COUNT.
- DONE: `done_out`=1 for exactly one cycle, `busy_out`=0 → IDLE.

Boundary rules:
- Overrun: if `run_len` > `pixels_left`, write only the remaining pixels, set `error_out`=1 and go to DONE. The unconsumed run is discarded.
- `error_out` holds until the next honoured `start_in` or `rst_in`.
- `start_in` in any state other than IDLE is ignored; there is no restart mid-frame.
- Address never wraps within a frame; a new frame restarts at 0.
- Widths: `pixels_left` is `AW`+1 bits. `run_len` is 9 bits.
- Counting is exact for non-power-of-2 `WIDTH*HEIGHT`.
- `rst_in` in any state, including mid-run, has these effects at the next edge:
  - State goes to IDLE.
  - `wr_en_out`=0, `busy_out`=0, `done_out`=0, `error_out`=0.
  - `wr_addr_out`=0, `wr_data_out`=0.
  - Partially written memory contents are left as-is.

## Timing
- Reset values: all outputs are 0, state IDLE, so `byte_ready_out`=0.
- All outputs except `byte_ready_out` are registered.
- `start_in` high at edge t → `busy_out`=1 and `byte_ready_out`=1 from t+1.
- Index byte accepted at edge t → `wr_en_out` high during cycles t+1 .. t+N for a run of N; addresses are consecutive and data is constant.
- After a run that does not finish the frame:
  - `byte_ready_out` is high the cycle after the last write.
  - Per-run overhead is therefore 2 cycles minimum (count and index), with no write bubbles inside a run.
- After the final write cycle: `done_out` is high in the very next cycle and `busy_out` is 0 in that same cycle.
- `byte_valid_in` gaps stall GET_COUNT/GET_INDEX indefinitely with no timeout.
- The writer is insensitive to BRAM read latency: the write port has no read dependency.

## Test plan
- `WIDTH`=4, `HEIGHT`=2: start, then bytes 0x07, 0x2A → 8 writes, addresses 0..7, data 0x2A on consecutive cycles; `done_out` pulse 1 cycle later; `error_out`=0.
- Same params, stream (0x02,0x11)(0x04,0x22) → address 0..2 data 0x11, then address 3..7 data 0x22; exactly 2 idle write cycles between runs; `done_out` once.
- Random `byte_valid_in` gaps (about 50% duty) on a 16×16 frame built from 1-pixel runs → 256 writes, one per accepted pair, addresses 0..255 in order, no duplicates or drops; checked against a software expansion.
- `WIDTH`=4, `HEIGHT`=2, stream (0x09,0x55) → exactly 8 writes of 0x55, then `error_out`=1 and `done_out` pulse. A following start clears `error_out`.
- `rst_in` asserted after the 3rd write of a 200-pixel run → `wr_en_out`=0 at the next edge; all outputs at reset values; a new start then loads a full frame correctly from address 0.
- `start_in` pulsed mid-run → ignored: write sequence, addresses and the `done_out` cycle are identical to the run without the pulse.

Source files
------------

// File: rtl/sprite_rle_loader.sv
// Expands (count, index) RLE byte pairs into raster-order BRAM writes, one pixel per cycle.
// A run costs two handshake cycles plus one write per pixel; byte_valid_in gaps stall the loader.
module sprite_rle_loader #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int AW     = $clog2(WIDTH * HEIGHT)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid_in,
  output logic          byte_ready_out,
  output logic [AW-1:0] wr_addr_out,
  output logic [7:0]    wr_data_out,
  output logic          wr_en_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          error_out
);

  localparam logic [AW:0] FRAME_PIX = (AW+1)'(WIDTH * HEIGHT);
  localparam logic [AW:0] ONE_PIX   = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    GET_COUNT,
    GET_INDEX,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  run_len;
  logic [AW:0] pixels_left;
  logic        last_pix;
  logic        run_end;

  assign byte_ready_out = (state == GET_COUNT) || (state == GET_INDEX);
  assign last_pix       = (pixels_left == ONE_PIX);
  assign run_end        = (run_len == 9'd1);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_in) state_nxt = GET_COUNT;
      GET_COUNT: if (byte_valid_in) state_nxt = GET_INDEX;
      GET_INDEX: if (byte_valid_in) state_nxt = WRITE;
      // Frame end wins over run end; any leftover run length is an overrun.
      WRITE: begin
        if (last_pix) begin
          state_nxt = DONE;
        end else if (run_end) begin
          state_nxt = GET_COUNT;
        end
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      run_len     <= '0;
      pixels_left <= '0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
      wr_en_out   <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            busy_out    <= 1'b1;
            wr_addr_out <= '0;
            pixels_left <= FRAME_PIX;
            error_out   <= 1'b0;
          end
        end
        GET_COUNT: begin
          if (byte_valid_in) run_len <= {1'b0, byte_in} + 9'd1;
        end
        GET_INDEX: begin
          if (byte_valid_in) begin
            wr_data_out <= byte_in;
            wr_en_out   <= 1'b1;
          end
        end
        WRITE: begin
          run_len     <= run_len - 9'd1;
          pixels_left <= pixels_left - ONE_PIX;
          // The address is held on the final pixel so it never wraps inside a frame.
          if (last_pix) begin
            wr_en_out <= 1'b0;
            busy_out  <= 1'b0;
            done_out  <= 1'b1;
            if (!run_end) error_out <= 1'b1;
          end else begin
            wr_addr_out <= wr_addr_out + AW'(1);
            if (run_end) wr_en_out <= 1'b0;
          end
        end
        DONE: begin
          done_out <= 1'b0;
        end
        default: begin
          wr_en_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
